// File: rtl/ccd_frame_capture.sv
// Sensor capture stage: registers the raw stream, gates whole frames with start/stop
// requests and emits pixel-valid with exact column/row coordinates and a frame count.
module ccd_frame_capture #(
  parameter int COLUMNS = 1280,
  parameter int CNT_W   = 11
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [11:0]      iDATA,
  input  logic             iFVAL,
  input  logic             iLVAL,
  input  logic             iSTART,
  input  logic             iEND,
  output logic [11:0]      oDATA,
  output logic             oDVAL,
  output logic [CNT_W-1:0] oX_Cont,
  output logic [CNT_W-1:0] oY_Cont,
  output logic [31:0]      oFrame_Cont,
  output logic             oLINE_ERR
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(COLUMNS - 1);

  state_t           state, state_nxt;
  logic [11:0]      d_DATA;
  logic             d_FVAL, d_LVAL, p_FVAL, p_LVAL;
  logic             stop_pending, stop_nxt;
  logic             frame_done, start_acc, enter_active;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic             fval_rise, fval_fall, lval_fall, pix, short_line;

  assign fval_rise  = d_FVAL & ~p_FVAL;
  assign fval_fall  = ~d_FVAL & p_FVAL;
  assign lval_fall  = ~d_LVAL & p_LVAL;
  assign pix        = (state == ACTIVE) & d_FVAL & d_LVAL;
  assign short_line = (state == ACTIVE) & lval_fall & (x_cnt != '0);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      stop_pending <= stop_nxt;
    end
  end

  // iEND has priority over iSTART in every state
  always_comb begin
    state_nxt    = state;
    stop_nxt     = stop_pending;
    frame_done   = 1'b0;
    start_acc    = 1'b0;
    enter_active = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART && !iEND) begin
          state_nxt = WAIT_FRAME;
          stop_nxt  = 1'b0;
          start_acc = 1'b1;
        end
      end
      WAIT_FRAME: begin
        if (iEND) state_nxt = IDLE;
        else if (fval_rise) begin
          state_nxt    = ACTIVE;
          enter_active = 1'b1;
        end
      end
      ACTIVE: begin
        if (iEND)        stop_nxt = 1'b1;
        else if (iSTART) stop_nxt = 1'b0;
        if (fval_fall) begin
          frame_done = 1'b1;
          state_nxt  = stop_nxt ? IDLE : WAIT_FRAME;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      d_DATA      <= '0;
      d_FVAL      <= 1'b0;
      d_LVAL      <= 1'b0;
      p_FVAL      <= 1'b0;
      p_LVAL      <= 1'b0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oLINE_ERR   <= 1'b0;
    end else begin
      d_DATA <= iDATA;
      d_FVAL <= iFVAL;
      d_LVAL <= iLVAL;
      p_FVAL <= d_FVAL;
      p_LVAL <= d_LVAL;
      oDATA  <= d_DATA;
      oDVAL  <= pix;

      if (enter_active) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (pix) begin
        oX_Cont <= x_cnt;
        oY_Cont <= y_cnt;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + CNT_W'(1);
        end else begin
          x_cnt <= x_cnt + CNT_W'(1);
        end
      end else if (short_line) begin
        // truncated line: realign so the next line starts at column 0
        x_cnt <= '0;
        y_cnt <= y_cnt + CNT_W'(1);
      end

      if (frame_done) oFrame_Cont <= oFrame_Cont + 32'd1;

      if (start_acc)       oLINE_ERR <= 1'b0;
      else if (short_line) oLINE_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Directed scenarios with random pixel data and random frame shapes, scored against a
// frame-level expectation queue built by the stimulus generator.
module tb_ccd_frame_capture;
  localparam int COLS = 8;
  localparam int CW   = 11;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic [11:0]   iDATA;
  logic          iFVAL, iLVAL, iSTART, iEND;
  logic [11:0]   oDATA;
  logic          oDVAL;
  logic [CW-1:0] oX_Cont, oY_Cont;
  logic [31:0]   oFrame_Cont;
  logic          oLINE_ERR;

  ccd_frame_capture #(.COLUMNS(COLS), .CNT_W(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
    .oLINE_ERR(oLINE_ERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct { logic [11:0] d; int x; int y; } pix_t;
  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // input data as it should reappear on oDATA two clocks later
  logic [11:0] h1, h2;
  always @(posedge iCLK or negedge iRST)
    if (!iRST) begin h1 <= '0; h2 <= '0; end
    else begin h1 <= iDATA; h2 <= h1; end

  always @(negedge iCLK) begin : mon
    pix_t p;
    if (mon_en && iRST === 1'b1) begin
      chk("odata_latency", 32'(oDATA), 32'(h2));
      if (oDVAL === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_dval", 32'(oDVAL), 32'd0);
        else begin
          p = exp_q.pop_front();
          chk("pix_data", 32'(oDATA), 32'(p.d));
          chk("pix_x", 32'(oX_Cont), 32'(p.x));
          chk("pix_y", 32'(oY_Cont), 32'(p.y));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge iCLK);
    iDATA  = 12'($urandom);
    iSTART = 1'b0;
    iEND   = 1'b0;
  endtask

  task automatic push(input int x, input int y);
    pix_t p;
    p.d = iDATA; p.x = x; p.y = y;
    exp_q.push_back(p);
  endtask

  task automatic line(input int len, input bit cap, input int y, input int end_at);
    for (int j = 0; j < len; j++) begin
      cyc();
      iLVAL = 1'b1;
      if (j == end_at) iEND = 1'b1;
      if (cap) push(j, y);
    end
    cyc(); iLVAL = 1'b0;
    cyc();
  endtask

  task automatic frame(input int nl, input int lens[4], input bit cap, input int end_line);
    cyc(); iFVAL = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < nl; i++) line(lens[i], cap, i, (i == end_line) ? lens[i] / 2 : -1);
    cyc(); iFVAL = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_odata"}, 32'(oDATA), 32'd0);
    chk({tag, "_odval"}, 32'(oDVAL), 32'd0);
    chk({tag, "_ox"}, 32'(oX_Cont), 32'd0);
    chk({tag, "_oy"}, 32'(oY_Cont), 32'd0);
    chk({tag, "_ocnt"}, oFrame_Cont, 32'd0);
    chk({tag, "_oerr"}, 32'(oLINE_ERR), 32'd0);
  endtask

  task automatic rst_pulse();
    @(negedge iCLK); #2 iRST = 1'b0;
    #1 chk_zero_outputs("rst_async");
    @(negedge iCLK); #2 iRST = 1'b1;
  endtask

  initial begin
    int lens[4];
    bit exp_err;
    iRST = 1'b0; iDATA = '0; iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0;
    repeat (3) @(negedge iCLK);
    chk_zero_outputs("reset");
    #2 iRST = 1'b1;
    mon_en = 1'b1;

    // basic 3x8 frame
    cyc(); iSTART = 1'b1;
    frame(3, '{8, 8, 8, 0}, 1'b1, -1);
    chk("s1_cnt", oFrame_Cont, 32'd1);
    chk("s1_err", 32'(oLINE_ERR), 32'd0);
    chk("s1_drained", 32'(exp_q.size()), 32'd0);
    cyc(); iEND = 1'b1;
    cyc();
    rst_pulse();

    // start while a frame is already in flight: that frame is skipped
    cyc(); iFVAL = 1'b1;
    cyc(); cyc();
    line(8, 1'b0, 0, -1);
    cyc(); iSTART = 1'b1;
    line(8, 1'b0, 0, -1);
    cyc(); iFVAL = 1'b0;
    repeat (4) cyc();
    chk("s2_skip_cnt", oFrame_Cont, 32'd0);
    frame(3, '{8, 8, 8, 0}, 1'b1, -1);
    chk("s2_cnt", oFrame_Cont, 32'd1);

    // stop mid-line: frame completes, next frame ignored
    frame(3, '{8, 8, 8, 0}, 1'b1, 1);
    chk("s3_cnt", oFrame_Cont, 32'd2);
    frame(2, '{8, 8, 0, 0}, 1'b0, -1);
    chk("s3_idle_cnt", oFrame_Cont, 32'd2);

    // short line then full lines
    cyc(); iSTART = 1'b1;
    frame(3, '{5, 8, 8, 0}, 1'b1, -1);
    chk("s4_err", 32'(oLINE_ERR), 32'd1);
    chk("s4_cnt", oFrame_Cont, 32'd3);
    cyc(); iEND = 1'b1;
    cyc();
    chk("s4_err_sticky", 32'(oLINE_ERR), 32'd1);
    cyc(); iSTART = 1'b1;
    cyc();
    chk("s4_err_clr", 32'(oLINE_ERR), 32'd0);

    // start and end together from IDLE
    cyc(); iEND = 1'b1;
    cyc(); iSTART = 1'b1; iEND = 1'b1;
    frame(2, '{8, 8, 0, 0}, 1'b0, -1);
    chk("s5_cnt", oFrame_Cont, 32'd3);

    // reset in the middle of a captured line
    cyc(); iSTART = 1'b1;
    cyc(); iFVAL = 1'b1;
    cyc(); cyc();
    line(8, 1'b1, 0, -1);
    for (int j = 0; j < 3; j++) begin
      cyc(); iLVAL = 1'b1;
      if (j < 2) push(j, 1);
    end
    rst_pulse();
    for (int j = 3; j < 8; j++) cyc();
    cyc(); iLVAL = 1'b0;
    cyc();
    line(8, 1'b0, 2, -1);
    cyc(); iFVAL = 1'b0;
    repeat (4) cyc();
    chk("s6_cnt", oFrame_Cont, 32'd0);
    chk("s6_drained", 32'(exp_q.size()), 32'd0);
    frame(2, '{8, 8, 0, 0}, 1'b0, -1);
    cyc(); iSTART = 1'b1;
    frame(2, '{8, 8, 0, 0}, 1'b1, -1);
    chk("s6_cnt_after", oFrame_Cont, 32'd1);

    // random frame shapes
    exp_err = 1'b0;
    for (int f = 0; f < 3; f++) begin
      int nl;
      nl = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) begin
        lens[i] = int'($urandom_range(1, COLS));
        if (i < nl && lens[i] < COLS) exp_err = 1'b1;
      end
      frame(nl, lens, 1'b1, -1);
    end
    chk("rnd_cnt", oFrame_Cont, 32'd4);
    chk("rnd_err", 32'(oLINE_ERR), 32'(exp_err));

    repeat (5) cyc();
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccd_frame_capture.md
# ccd_frame_capture

Sensor-side capture stage sitting directly upstream of the Bayer-to-grayscale/Sobel image processing stage. Samples the raw 12-bit sensor stream qualified by frame-valid/line-valid, gates capture with start/stop requests, and produces a pixel-valid strobe with column/row coordinates and a frame counter. Downstream uses coordinate LSBs for 2x2 Bayer decimation, so coordinates must be exact and aligned with data.

## Interface
- COLUMNS, 1280: active pixels per line; X wraps at COLUMNS-1.
- CNT_W, 11: width of X/Y coordinate outputs.

- iCLK  in  1  pixel clock; all logic rising-edge.
- iRST  in  1  reset, asynchronous, active-low.
- iDATA  in  12  raw sensor pixel.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iSTART  in  1  capture start request, single-cycle pulse.
- iEND  in  1  capture stop request, single-cycle pulse.
- oDATA  out  12  registered pixel.
- oDVAL  out  1  pixel valid, aligned with oDATA.
- oX_Cont  out  CNT_W  column of pixel on oDATA.
- oY_Cont  out  CNT_W  row of pixel on oDATA.
- oFrame_Cont  out  32  completed captured frames.
- oLINE_ERR  out  1  sticky: short line detected.

## Operation
- Stage 1: register iDATA/iFVAL/iLVAL to d_DATA/d_FVAL/d_LVAL; keep p_FVAL, p_LVAL (previous d_ values) for edge detect.
- States: IDLE (reset), WAIT_FRAME, ACTIVE.
- IDLE: iSTART -> WAIT_FRAME, clears stop_pending.
- WAIT_FRAME: d_FVAL rise (d_FVAL & !p_FVAL) -> ACTIVE, X<=0, Y<=0. Frame already in progress at start is skipped. iEND -> IDLE immediately.
- ACTIVE: d_FVAL fall -> oFrame_Cont+1; then IDLE if stop_pending, else WAIT_FRAME. iEND sets stop_pending (frame completes). iSTART clears stop_pending.
- iSTART and iEND same cycle: iEND wins in every state.
- Pixel qualify: pix = ACTIVE & d_FVAL & d_LVAL.
- On pix: oX_Cont<=X, oY_Cont<=Y, then X==COLUMNS-1 ? (X<=0, Y<=Y+1) : X<=X+1.
- Short line: in ACTIVE, d_LVAL fall with X!=0 -> X<=0, Y<=Y+1, oLINE_ERR<=1. X==0 at fall (exact full line) -> no action.
- Y wraps modulo 2^CNT_W; frame counter wraps modulo 2^32.
- oLINE_ERR clears only on reset or iSTART accepted in IDLE.
- oDATA<=d_DATA every cycle; oDVAL<=pix; oX_Cont/oY_Cont hold when !pix.

## Timing
- Reset values: oDATA=0, oDVAL=0, oX_Cont=0, oY_Cont=0, oFrame_Cont=0, oLINE_ERR=0, state IDLE, all internal registers 0.
- Latency: iDATA/iLVAL/iFVAL sampled at edge n -> oDATA/oDVAL/coords at edge n+2; fixed, no stalls, no backpressure.
- First pixel of a frame: oDVAL=1 with X=0, Y=0.
- iSTART/iEND act on the edge they are sampled (not registered).
- Frame-counter increment visible one cycle after d_FVAL fall registered.
- Reset mid-frame: all outputs return to reset values asynchronously; after release, capture waits for iSTART and a fresh FVAL rise.

## Test plan
- COLUMNS=8: iSTART, then frame of 3 lines x 8 pixels (data=ramp 0..23) -> 24 oDVAL pulses, (X,Y) (0,0)..(7,2), oDATA ramp 0..23 two cycles after input, oFrame_Cont=1.
- iSTART asserted while iFVAL already high mid-frame -> no oDVAL for that frame; next full frame captured, oFrame_Cont=1.
- iEND pulsed mid-line of frame 2 -> frame 2 completes fully, oFrame_Cont=2, state IDLE, frame 3 produces no oDVAL.
- Line of 5 pixels (COLUMNS=8) then full line -> oLINE_ERR=1, second line reported Y=1, X 0..7; next iSTART from IDLE clears oLINE_ERR.
- iSTART and iEND in same cycle from IDLE -> stays IDLE, no oDVAL on following frame.
- iRST low for 1 cycle mid-line -> all outputs 0 immediately; no oDVAL until iSTART plus new FVAL rise.
